// File: rtl/sgdmac_pkg.sv
// Shared SGDMAC definitions: channel tags, dispatcher states and the beat record
// used on the read-return path.
package sgdmac_pkg;

  localparam logic CH_DESC = 1'b0;
  localparam logic CH_DATA = 1'b1;

  localparam int BEAT_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    BURST_DESC,
    BURST_DATA
  } state_t;

  typedef struct packed {
    logic                   last;
    logic [BEAT_DATA_W-1:0] data;
  } beat_t;

endpackage

// File: rtl/sgdmac_stream_fifo.sv
// Small registered FIFO feeding one dispatcher sink; no write-to-read bypass, so a
// pushed beat shows up at the head one cycle later at the earliest.
module sgdmac_stream_fifo #(
  parameter int DATA_SIZE  = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic                          push_last,
  input  logic [DATA_SIZE-1:0]          push_data,
  output logic                          full,
  input  logic                          pop,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          head_last,
  output logic [DATA_SIZE-1:0]          head_data
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_SIZE:0] mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;

  // Storage is cleared too so the sink data pins never carry X out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {push_last, push_data};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign full      = (count == CW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign head_last = mem[rd_ptr][DATA_SIZE];
  assign head_data = mem[rd_ptr][DATA_SIZE-1:0];

endmodule

// File: rtl/sgdmac_dispatcher.sv
// Routes tagged read-return bursts to the descriptor fetcher or the data writer,
// locking the channel from the first beat until the last beat is accepted.
module sgdmac_dispatcher
  import sgdmac_pkg::*;
#(
  parameter int DATA_SIZE  = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 src_valid_i,
  output logic                 src_ready_o,
  input  logic [DATA_SIZE-1:0] src_data_i,
  input  logic                 src_id_i,
  input  logic                 src_last_i,
  output logic                 desc_valid_o,
  input  logic                 desc_ready_i,
  output logic [DATA_SIZE-1:0] desc_data_o,
  output logic                 desc_last_o,
  output logic                 data_valid_o,
  input  logic                 data_ready_i,
  output logic [DATA_SIZE-1:0] data_data_o,
  output logic                 data_last_o,
  output logic                 busy_o,
  output logic                 id_err_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t         state, state_nxt;
  logic           sel, acc;
  logic           full_desc, full_data, empty_desc, empty_data;
  logic [CW-1:0]  cnt_desc, cnt_data;

  always_comb begin
    sel = src_id_i;
    case (state)
      BURST_DESC: sel = CH_DESC;
      BURST_DATA: sel = CH_DATA;
      default:    sel = src_id_i;
    endcase
  end

  // Ready looks only at the selected FIFO, so a stalled sink blocks the source
  // only while the source is aimed at it.
  assign src_ready_o = rst_n & ~((sel == CH_DATA) ? full_data : full_desc);
  assign acc         = src_valid_i & src_ready_o;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (acc && !src_last_i) state_nxt = (sel == CH_DATA) ? BURST_DATA : BURST_DESC;
      BURST_DESC,
      BURST_DATA: if (acc && src_last_i)  state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Mismatched tag mid-burst is flagged but the beat still follows the lock.
  always_ff @(posedge clk) begin
    if (!rst_n)                                         id_err_o <= 1'b0;
    else if (acc && state != IDLE && src_id_i != sel)   id_err_o <= 1'b1;
  end

  sgdmac_stream_fifo #(.DATA_SIZE(DATA_SIZE), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo_desc (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (acc && sel == CH_DESC),
    .push_last (src_last_i),
    .push_data (src_data_i),
    .full      (full_desc),
    .pop       (desc_valid_o & desc_ready_i),
    .empty     (empty_desc),
    .count     (cnt_desc),
    .head_last (desc_last_o),
    .head_data (desc_data_o)
  );

  sgdmac_stream_fifo #(.DATA_SIZE(DATA_SIZE), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo_data (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (acc && sel == CH_DATA),
    .push_last (src_last_i),
    .push_data (src_data_i),
    .full      (full_data),
    .pop       (data_valid_o & data_ready_i),
    .empty     (empty_data),
    .count     (cnt_data),
    .head_last (data_last_o),
    .head_data (data_data_o)
  );

  assign desc_valid_o = ~empty_desc;
  assign data_valid_o = ~empty_data;
  assign busy_o       = (state != IDLE) | (cnt_desc != '0) | (cnt_data != '0);

endmodule

// File: tb/tb_sgdmac_dispatcher.sv
// Random-stimulus bench for sgdmac_dispatcher against a queue-based model of the
// two sinks and the burst lock.
module tb_sgdmac_dispatcher;
  import sgdmac_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          src_valid_i, src_id_i, src_last_i;
  logic [DW-1:0] src_data_i;
  logic          src_ready_o;
  logic          desc_valid_o, desc_ready_i, desc_last_o;
  logic [DW-1:0] desc_data_o;
  logic          data_valid_o, data_ready_i, data_last_o;
  logic [DW-1:0] data_data_o;
  logic          busy_o, id_err_o;

  sgdmac_dispatcher #(.DATA_SIZE(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .src_valid_i(src_valid_i), .src_ready_o(src_ready_o), .src_data_i(src_data_i),
    .src_id_i(src_id_i), .src_last_i(src_last_i),
    .desc_valid_o(desc_valid_o), .desc_ready_i(desc_ready_i),
    .desc_data_o(desc_data_o), .desc_last_o(desc_last_o),
    .data_valid_o(data_valid_o), .data_ready_i(data_ready_i),
    .data_data_o(data_data_o), .data_last_o(data_last_o),
    .busy_o(busy_o), .id_err_o(id_err_o)
  );

  always #5 clk = ~clk;

  // Model: one queue per sink, open burst channel (-1 = none), sticky error.
  beat_t q[2][$];
  int    open_ch;
  bit    err;
  int    total, bad;
  int    seq;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int cur_sel();
    return (open_ch < 0) ? int'(src_id_i) : open_ch;
  endfunction

  task automatic check_outputs();
    chk("src_ready", src_ready_o, q[cur_sel()].size() < DEPTH);
    chk("desc_valid", desc_valid_o, q[0].size() != 0);
    chk("data_valid", data_valid_o, q[1].size() != 0);
    if (q[0].size() != 0) begin
      chk("desc_data", desc_data_o, q[0][0].data);
      chk("desc_last", desc_last_o, q[0][0].last);
    end
    if (q[1].size() != 0) begin
      chk("data_data", data_data_o, q[1][0].data);
      chk("data_last", data_last_o, q[1][0].last);
    end
    chk("busy", busy_o, (open_ch >= 0) || q[0].size() != 0 || q[1].size() != 0);
    chk("id_err", id_err_o, err);
  endtask

  // One cycle with rst_n low: source must be refused, model is wiped at the edge.
  task automatic reset_cycle();
    @(negedge clk);
    rst_n       = 1'b0;
    src_valid_i = 1'b1;
    src_id_i    = 1'($urandom);
    #1 chk("ready_in_reset", src_ready_o, 1'b0);
    @(posedge clk);
    q[0].delete();
    q[1].delete();
    open_ch = -1;
    err     = 1'b0;
  endtask

  task automatic run_cycle(input int vld_pct, input int rdy_pct, input int err_pct);
    bit    acc, pop0, pop1;
    int    sel;
    beat_t b;
    @(negedge clk);
    rst_n        = 1'b1;
    src_valid_i  = ($urandom_range(0, 99) < vld_pct);
    src_last_i   = ($urandom_range(0, 2) == 0);
    src_data_i   = {16'($urandom), 16'(seq)};
    desc_ready_i = ($urandom_range(0, 99) < rdy_pct);
    data_ready_i = ($urandom_range(0, 99) < rdy_pct);
    if (open_ch >= 0 && $urandom_range(0, 99) >= err_pct) src_id_i = open_ch[0];
    else                                                  src_id_i = 1'($urandom);
    #1 check_outputs();
    sel  = cur_sel();
    acc  = src_valid_i && (q[sel].size() < DEPTH);
    pop0 = desc_ready_i && q[0].size() != 0;
    pop1 = data_ready_i && q[1].size() != 0;
    @(posedge clk);
    if (pop0) void'(q[0].pop_front());
    if (pop1) void'(q[1].pop_front());
    if (acc) begin
      seq++;
      b.last = src_last_i;
      b.data = src_data_i;
      q[sel].push_back(b);
      if (open_ch >= 0 && int'(src_id_i) != open_ch) err = 1'b1;
      if (src_last_i)        open_ch = -1;
      else if (open_ch < 0)  open_ch = sel;
    end
  endtask

  initial begin
    total = 0; bad = 0; seq = 0;
    open_ch = -1; err = 1'b0;
    src_valid_i = 0; src_id_i = 0; src_last_i = 0; src_data_i = '0;
    desc_ready_i = 0; data_ready_i = 0;
    rst_n = 1'b0;
    reset_cycle();
    reset_cycle();
    // reset state is checked by the first run_cycle (valids, busy, id_err all 0)
    for (int p = 0; p < 6; p++) begin
      int vp, rp, ep;
      case (p)
        0: begin vp = 100; rp = 100; ep = 0;  end  // back-to-back streaming
        1: begin vp = 80;  rp = 20;  ep = 0;  end  // sinks mostly stalled
        2: begin vp = 60;  rp = 60;  ep = 0;  end
        3: begin vp = 90;  rp = 40;  ep = 5;  end  // occasional tag mismatch
        4: begin vp = 70;  rp = 70;  ep = 0;  end
        default: begin vp = 50; rp = 90; ep = 10; end
      endcase
      for (int c = 0; c < 600; c++) begin
        if ($urandom_range(0, 199) == 0) reset_cycle();
        run_cycle(vp, rp, ep);
      end
      reset_cycle();
    end
    // Drain with full readiness, no new beats, then the block must go idle.
    for (int c = 0; c < 8; c++) run_cycle(0, 100, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
